// File: rtl/ghazi_loader_pkg.sv
// Shared types and the CRC-8 step for the ICCM UART loader.
// The CRC helper is used by the loader when GHAZI_LOADER_CRC_EN is defined.
package ghazi_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CRC,
      ST_DONE,
      ST_ERR
   } loader_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_CRC     = 2'd3
   } err_code_e;

   localparam logic [7:0] LOADER_CRC_POLY = 8'h07;

   // One byte of CRC-8, MSB first, no reflection, no final xor.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data_byte);
      logic [7:0] c;
      c = crc ^ data_byte;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ LOADER_CRC_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/iccm_uart_loader.sv
// Boot loader: parses sync/length/data(/CRC) frames from the UART and writes ICCM words.
// Optional CRC-8 trailer check is enabled by defining GHAZI_LOADER_CRC_EN.
module iccm_uart_loader
   import ghazi_loader_pkg::*;
#(
   parameter int         ADDR_W         = 14,
   parameter int         MAX_WORDS      = 256,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rx_dv_i,
   input  logic [7:0]        rx_byte_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [31:0]       wdata_o,
   output logic              reset_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   // rx_dv_i is a single-cycle strobe qualifying rx_byte_i; there is no ready,
   // every strobe is consumed in the cycle it arrives.
`ifdef GHAZI_LOADER_CRC_EN
   localparam loader_state_e PAYLOAD_END = ST_CRC;
`else
   localparam loader_state_e PAYLOAD_END = ST_DONE;
`endif

   loader_state_e     state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              reset_q, reset_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   err_code_e         err_code_q, err_code_d;
   logic              tmo_fire;
   logic [15:0]       len_rx;
   logic              last_word;
`ifdef GHAZI_LOADER_CRC_EN
   logic [7:0]        crc_q, crc_d;
`endif

   assign len_rx    = {rx_byte_i, count_q[7:0]};
   assign last_word = (32'(word_idx_q) + 32'd1) == 32'(count_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         word_idx_q <= '0;
         tmo_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         reset_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
`ifdef GHAZI_LOADER_CRC_EN
         crc_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         word_idx_q <= word_idx_d;
         tmo_q      <= tmo_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         reset_q    <= reset_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
`ifdef GHAZI_LOADER_CRC_EN
         crc_q      <= crc_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      word_idx_d = word_idx_q;
      tmo_d      = tmo_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      reset_d    = reset_q;
      done_d     = done_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      tmo_fire   = 1'b0;

      // A byte arriving on the would-be timeout cycle wins over the timeout.
      if (rx_dv_i) begin
         tmo_d = '0;
      end else if (state_q != ST_IDLE && state_q != ST_DONE) begin
         if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_fire = 1'b1;
         else                                    tmo_d = tmo_q + TMO_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (rx_dv_i && rx_byte_i == SYNC_BYTE) begin
               state_d    = ST_LEN_LO;
               err_d      = 1'b0;
               err_code_d = ERR_NONE;
               word_idx_d = '0;
               byte_idx_d = '0;
            end
         end
         ST_LEN_LO: begin
            if (rx_dv_i) begin
               count_d[7:0] = rx_byte_i;
               state_d      = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (rx_dv_i) begin
               count_d[15:8] = rx_byte_i;
               if (len_rx > 16'(MAX_WORDS)) begin
                  state_d    = ST_ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_LEN;
               end else if (len_rx == 16'd0) begin
                  state_d = PAYLOAD_END;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rx_dv_i) begin
               word_d     = {rx_byte_i, word_q[31:8]};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  addr_d     = word_idx_q;
                  wdata_d    = {rx_byte_i, word_q[31:8]};
                  word_idx_d = word_idx_q + ADDR_W'(1);
                  if (last_word) state_d = PAYLOAD_END;
               end
            end
         end
`ifdef GHAZI_LOADER_CRC_EN
         ST_CRC: begin
            if (rx_dv_i) begin
               if (rx_byte_i == crc_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_CRC;
               end
            end
         end
`endif
         ST_ERR:  state_d = ST_IDLE;
         default: ;
      endcase

      if (tmo_fire) begin
         state_d    = ST_ERR;
         err_d      = 1'b1;
         err_code_d = ERR_TIMEOUT;
      end
      if (state_d == ST_ERR) tmo_d = '0;
      if (state_d == ST_DONE) begin
         reset_d = 1'b1;
         done_d  = 1'b1;
      end
   end

`ifdef GHAZI_LOADER_CRC_EN
   // Sync is excluded from the CRC; length and data bytes are folded in.
   always_comb begin
      crc_d = crc_q;
      if (state_q == ST_IDLE && rx_dv_i && rx_byte_i == SYNC_BYTE)
         crc_d = '0;
      else if (rx_dv_i && (state_q == ST_LEN_LO || state_q == ST_LEN_HI || state_q == ST_DATA))
         crc_d = crc8_update(crc_q, rx_byte_i);
   end
`endif

   assign we_o       = we_q;
   assign addr_o     = addr_q;
   assign wdata_o    = wdata_q;
   assign reset_o    = reset_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign err_code_o = err_code_q;

endmodule

// File: tb/tb_iccm_uart_loader.sv
// Self-checking bench for iccm_uart_loader (build with or without GHAZI_LOADER_CRC_EN).
module tb_iccm_uart_loader;
   import ghazi_loader_pkg::*;

   localparam int         ADDR_W    = 14;
   localparam int         MAX_WORDS = 256;
   localparam int         TMO       = 50;
   localparam logic [7:0] SYNC      = 8'hA5;
`ifdef GHAZI_LOADER_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_dv = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic              we_o;
   logic [ADDR_W-1:0] addr_o;
   logic [31:0]       wdata_o;
   logic              reset_o;
   logic              done_o;
   logic              err_o;
   logic [1:0]        err_code_o;

   int checks = 0;
   int failures = 0;
   logic [ADDR_W+31:0] exp_q[$];

   typedef struct {
      int         junk;
      int         count;
      bit         corrupt;
      bit         exp_done;
      logic [1:0] exp_code;
   } vec_t;
   vec_t tbl[9];

   // ---------------- clock / reset / DUT ----------------
   always #5 clk = ~clk;

   iccm_uart_loader #(
      .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
      .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .reset_o(reset_o),
      .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- scoreboard: every write must match the next expected one ----------------
   always @(negedge clk) begin
      if (rst_n && we_o) begin
         logic [ADDR_W+31:0] e;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else                   e = 'x;
         check("sram_write", {addr_o, wdata_o}, e);
      end
   end

   // ---------------- driver tasks (entered on a negedge) ----------------
   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_dv   = 1'b1;
      @(negedge clk);
      rx_dv   = 1'b0;
      repeat (7) @(negedge clk);
   endtask

   task automatic do_reset();
      rx_dv = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {we_o, addr_o, wdata_o, reset_o, done_o, err_o, err_code_o}, 64'd0);
      exp_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Builds a frame from random words; queues the writes a correct loader must make.
   // max_data < 0 sends the whole payload, otherwise stops after that many data bytes.
   task automatic run_frame(input int junk, input int count, input bit corrupt, input int max_data);
      logic [7:0]  b;
      logic [7:0]  crc;
      logic [31:0] w;
      int          sent;
      for (int k = 0; k < junk; k++) begin
         b = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom_range(0, 255));
         if (b == SYNC) b = 8'h3C;
         send_byte(b);
      end
      send_byte(SYNC);
      crc = 8'h00;
      b = count[7:0];  crc = crc8_update(crc, b); send_byte(b);
      b = count[15:8]; crc = crc8_update(crc, b); send_byte(b);
      if (count > MAX_WORDS) return;
      sent = 0;
      for (int i = 0; i < count; i++) begin
         w = $urandom();
         for (int j = 0; j < 4; j++) begin
            if (max_data >= 0 && sent == max_data) return;
            if (j == 3) exp_q.push_back({ADDR_W'(i), w});
            b = w[8*j +: 8];
            crc = crc8_update(crc, b);
            send_byte(b);
            sent++;
         end
      end
      if (CRC_ON) send_byte(corrupt ? (crc ^ 8'h01) : crc);
   endtask

   // Frame outcome straight from the framing rules.
   function automatic void model_outcome(input int count, input bit corrupt,
                                         output bit done, output logic [1:0] code);
      if (count > MAX_WORDS)        begin done = 1'b0; code = 2'd1; end
      else if (CRC_ON && corrupt)   begin done = 1'b0; code = 2'd3; end
      else                          begin done = 1'b1; code = 2'd0; end
   endfunction

   task automatic check_outcome(input string tag, input bit exp_done, input logic [1:0] exp_code);
      check({tag, "_done"},        done_o,       exp_done);
      check({tag, "_reset"},       reset_o,      exp_done);
      check({tag, "_err"},         err_o,        exp_code != 2'd0);
      check({tag, "_code"},        err_code_o,   exp_code);
      check({tag, "_writes_left"}, exp_q.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] fa[$];
      logic [7:0] crc;
      bit         md;
      logic [1:0] mc;
      int         cnt;

      tbl[0] = '{0, 1,     1'b0, 1'b1,    2'd0};
      tbl[1] = '{2, 1,     1'b0, 1'b1,    2'd0};
      tbl[2] = '{0, 0,     1'b0, 1'b1,    2'd0};
      tbl[3] = '{0, 257,   1'b0, 1'b0,    2'd1};
      tbl[4] = '{0, 65535, 1'b0, 1'b0,    2'd1};
      tbl[5] = '{0, 256,   1'b0, 1'b1,    2'd0};
      tbl[6] = '{1, 5,     1'b0, 1'b1,    2'd0};
      tbl[7] = '{0, 3,     1'b1, !CRC_ON, CRC_ON ? 2'd3 : 2'd0};
      tbl[8] = '{0, 0,     1'b1, !CRC_ON, CRC_ON ? 2'd3 : 2'd0};

      @(negedge clk);
      do_reset();

      // Reference frame with fixed words; done must not rise before the final byte.
      fa = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      crc = 8'h00;
      for (int i = 1; i < fa.size(); i++) crc = crc8_update(crc, fa[i]);
      if (CRC_ON) fa.push_back(crc);
      exp_q.push_back({ADDR_W'(0), 32'h12345678});
      exp_q.push_back({ADDR_W'(1), 32'hDEADBEEF});
      for (int i = 0; i < fa.size(); i++) begin
         if (i == fa.size() - 1) check("frameA_done_early", {done_o, reset_o}, 2'b00);
         send_byte(fa[i]);
      end
      check_outcome("frameA", 1'b1, 2'd0);

      // Table-driven frames, each from reset.
      for (int t = 0; t < 9; t++) begin
         do_reset();
         run_frame(tbl[t].junk, tbl[t].count, tbl[t].corrupt, -1);
         check_outcome($sformatf("tbl%0d", t), tbl[t].exp_done, tbl[t].exp_code);
      end

      // Length error then a good frame without reset.
      do_reset();
      run_frame(0, 257, 1'b0, -1);
      check_outcome("lenerr", 1'b0, 2'd1);
      run_frame(0, 2, 1'b0, -1);
      check_outcome("lenerr_recover", 1'b1, 2'd0);

      // Stall after two data bytes: error exactly TMO clocks after the last byte.
      do_reset();
      run_frame(0, 1, 1'b0, 2);
      repeat (TMO - 8) @(negedge clk);
      check("tmo_early", err_o, 1'b0);
      @(negedge clk);
      check("tmo_err", err_o, 1'b1);
      check("tmo_code", err_code_o, 2'd2);
      check("tmo_reset", reset_o, 1'b0);
      @(negedge clk);
      run_frame(0, 2, 1'b0, -1);
      check_outcome("tmo_recover", 1'b1, 2'd0);

      // Asynchronous reset in the middle of DATA.
      do_reset();
      run_frame(0, 3, 1'b0, 6);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {we_o, addr_o, wdata_o, reset_o, done_o, err_o, err_code_o}, 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(0, 1, 1'b0, -1);
      check_outcome("after_async", 1'b1, 2'd0);

      // Randomised frames against the outcome model.
      for (int r = 0; r < 8; r++) begin
         do_reset();
         cnt = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 6) : $urandom_range(MAX_WORDS + 1, 600);
         md = 1'b0;
         mc = 2'd0;
         model_outcome(cnt, 1'($urandom_range(0, 1)), md, mc);
         run_frame($urandom_range(0, 3), cnt, mc == 2'd3, -1);
         check_outcome($sformatf("rand%0d", r), md, mc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog time=%0t limit=2000000", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iccm_uart_loader.md
Name: iccm_uart_loader

Overview:
- Boot-time program loader between the UART byte receiver (uart_rx_prog) and the instruction SRAM write port.
- Parses a framed byte stream (sync, word count, little-endian data words, optional CRC-8) and emits one-cycle SRAM word writes.
- Holds the core in reset (reset_o low) until a complete, valid frame has been loaded.
- Replaces the bare word packer with framing, bounds checking, inter-byte timeout and error reporting.

Parameters:
- ADDR_W, 14, word-address width of the instruction SRAM port.
- MAX_WORDS, 256, largest accepted word count; must be ≤ 2**ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- rx_dv_i  in  1  one-cycle strobe: rx_byte_i is valid.
- rx_byte_i  in  8  received UART byte.
- we_o  out  1  one-cycle SRAM write strobe.
- addr_o  out  ADDR_W  SRAM word address for the current write.
- wdata_o  out  32  SRAM write data.
- reset_o  out  1  core reset release; 0 = hold core in reset.
- done_o  out  1  sticky; frame loaded successfully.
- err_o  out  1  sticky; last frame failed.
- err_code_o  out  2  failure cause: 0 none, 1 length > MAX_WORDS, 2 timeout, 3 CRC mismatch.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. All outputs 0: we_o, addr_o, wdata_o, reset_o, done_o, err_o, err_code_o. Word index, byte index, timeout counter and CRC are cleared.
- States: IDLE → LEN_LO → LEN_HI → DATA → (CRC) → DONE. ERR is a one-cycle transit state back to IDLE.
- IDLE:
  - rx_dv_i with SYNC_BYTE → LEN_LO. Clear err_o, err_code_o, word index and CRC.
  - Any other byte is ignored.
- LEN_LO: latch count[7:0]. LEN_HI: latch count[15:8].
  - count > MAX_WORDS → ERR, code 1.
  - count == 0 → CRC state if the CRC feature is compiled in, else DONE.
  - Otherwise → DATA.
- DATA:
  - Bytes pack little-endian: the first byte goes to wdata[7:0].
  - On the 4th byte's rx_dv_i, assert we_o on the following cycle for exactly one clock, with addr_o = word index and wdata_o = assembled word.
  - Word index increments after the write.
  - After write number count → CRC state or DONE.
- DONE: reset_o = 1 and done_o = 1, both registered. All further bytes are ignored until rst_ni asserts; there is no reload while the core runs.
- Timeout:
  - Counter runs in every state except IDLE and DONE, and clears on every rx_dv_i.
  - Reaching TIMEOUT_CYCLES → ERR, code 2.
- ERR:
  - Set err_o and err_code_o; return to IDLE next cycle. reset_o stays 0.
  - Words already written remain in SRAM; the next frame overwrites them.
- SRAM throughput: rx_dv_i strobes are at least 8 clocks apart (UART rate), so no write back-pressure exists.
- Simultaneous events: rx_dv_i on the same cycle the timeout would fire counts as a byte; the timeout does not trigger.

Optional Feature:
- Macro: GHAZI_LOADER_CRC_EN.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first) is computed over the two length bytes and all data bytes. SYNC_BYTE is excluded.
  - After the data, one CRC byte is expected. Match → DONE. Mismatch → ERR, code 3.
  - The CRC update is combinational per byte and registered on rx_dv_i.
- Undefined:
  - No CRC state and no CRC logic; DATA completion goes straight to DONE.
  - Code 3 is never produced.

Decomposition:
- Package ghazi_loader_pkg holds:
  - loader_state_e enum;
  - err_code_e enum (ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_CRC);
  - LOADER_CRC_POLY = 8'h07;
  - function crc8_update(crc, byte).
- Single FSM module, no sub-modules. crc8_update lives in the package so the bench's reference model reuses it.

Test Plan:
- Frame A5 02 00 | 78 56 34 12 | EF BE AD DE (plus CRC byte if enabled) → we_o at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF; reset_o and done_o rise after the last byte (or after the CRC byte); exactly 2 we_o pulses.
- Bytes 00 FF before A5 01 00 + 1 word → leading bytes ignored; single write at addr 0.
- Length 0x0101 (257) with MAX_WORDS = 256 → no we_o; err_o = 1, err_code_o = 1; reset_o = 0; a following valid frame loads and sets done_o.
- Frame stalls after 2 data bytes (TIMEOUT_CYCLES = 50 in bench) → err_code_o = 2 at cycle 50 after the last byte; state returns to IDLE.
- GHAZI_LOADER_CRC_EN: 1-word frame with a corrupted CRC byte → write occurs, err_code_o = 3, reset_o = 0. Same frame with the correct CRC → done_o = 1.
- Assert rst_ni mid-DATA → all outputs 0 immediately (asynchronous); a complete frame after release loads from addr 0.
